stream_framer: RTL and testbench
================================

STREAM_FRAMER -- requirements
Module: stream_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel data width in bits.
REQ-002 SHALL have parameter IMG_W, default 1280, pixels per line.
REQ-003 SHALL have parameter IMG_H, default 720, lines per frame.
REQ-004 SHALL have parameter LAST_MODE, default 0; 0 = Last_out on the final pixel of the frame, 1 = Last_out on the final pixel of every line.
REQ-005 Ports:
- Clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- Valid_in  input  1  upstream data valid.
- Data_in  input  DATA_W  upstream pixel.
- Ready_out  output  1  block can accept a pixel.
- Valid_out  output  1  downstream beat valid.
- Data_out  output  DATA_W  downstream pixel.
- Last_out  output  1  end-of-frame or end-of-line marker, per LAST_MODE.
- User_out  output  1  start-of-frame marker, high on pixel (row 0, col 0).
- Ready_in  input  1  downstream ready.
- Frame_done  output  1  one-cycle pulse per completed frame.
- Ovf_out  output  1  sticky overflow flag (see Configuration).

Function
REQ-006 Input handshake SHALL complete when Valid_in && Ready_out; output handshake SHALL complete when Valid_out && Ready_in.
REQ-007 SHALL buffer pixels in a 2-entry skid FIFO; Ready_out SHALL be registered, high iff fewer than 2 entries are occupied.
REQ-008 Latency SHALL be 1 cycle: a pixel accepted at edge N into an empty buffer SHALL appear on Valid_out/Data_out after edge N.
REQ-009 While Valid_out && !Ready_in, Data_out, Last_out and User_out SHALL hold stable.
REQ-010 Simultaneous push and pop SHALL leave occupancy unchanged and lose no data, including when the buffer is full.
REQ-011 Column counter col (width clog2(IMG_W)) SHALL advance on each output handshake and wrap IMG_W-1 -> 0; row (width clog2(IMG_H)) SHALL then increment, wrapping IMG_H-1 -> 0.
REQ-012 User_out SHALL be high with Valid_out exactly when col==0 && row==0.
REQ-013 LAST_MODE=0: Last_out SHALL be high with Valid_out iff col==IMG_W-1 && row==IMG_H-1. LAST_MODE=1: iff col==IMG_W-1.
REQ-014 Frame_done SHALL pulse for one cycle, on the cycle after the output handshake of pixel (IMG_H-1, IMG_W-1).
REQ-015 Valid_in while Ready_out is low SHALL drop that pixel; the counters SHALL NOT advance for it.
REQ-016 Frame position SHALL be derived from output handshakes only; upstream gaps SHALL NOT affect framing.

Reset
REQ-017 Asserting rst_n low SHALL immediately clear: buffer empty, col=0, row=0, Valid_out=0, Last_out=0, User_out=0, Frame_done=0, Ovf_out=0, Data_out=0, Ready_out=0.
REQ-018 Ready_out SHALL go high on the first rising Clk edge after rst_n deasserts.
REQ-019 Reset mid-frame SHALL discard buffered pixels; the next output pixel SHALL carry User_out=1.

Configuration
REQ-020 With macro STREAM_FRAMER_OVF_EN defined, Ovf_out SHALL set on the edge after any cycle with Valid_in && !Ready_out, and stay high until reset.
REQ-021 Without STREAM_FRAMER_OVF_EN, Ovf_out SHALL be constant 0 and no overflow logic SHALL be synthesised; all other behaviour is identical.

Verification
REQ-022 Bench parameters SHALL be DATA_W=8, IMG_W=4, IMG_H=2, and the bench SHALL cover these scenarios:
- LAST_MODE=0, continuous Valid_in, Ready_in=1, data 0..7: Data_out 0..7 at 1-cycle latency; User_out only on 0; Last_out only on 7; Frame_done pulses once, one cycle after the 7 handshake.
- LAST_MODE=1, same stimulus: Last_out on data 3 and 7 only.
- Ready_in=0 for 5 cycles mid-frame with Valid_in held high: Ready_out drops after 2 accepts; Data_out stable; after release all 8 pixels arrive in order, none lost.
- Random Valid_in and Ready_in over 3 frames: output sequence equals accepted input sequence; User_out every 8th beat; Frame_done count = 3.
- rst_n pulsed low after 5 beats: outputs clear immediately; the next accepted pixel emerges with User_out=1.
- STREAM_FRAMER_OVF_EN defined, Valid_in=1 while Ready_out=0: Ovf_out=1 on the next edge and held. Without the macro: Ovf_out stays 0.

Source files
------------

// File: rtl/stream_framer_if.sv
// Pixel stream bundle for stream_framer: upstream handshake, downstream
// handshake with frame markers, and the status outputs.
interface stream_framer_if #(
   parameter int DATA_W = 8
);
   logic              Valid_in;
   logic [DATA_W-1:0] Data_in;
   logic              Ready_out;
   logic              Valid_out;
   logic [DATA_W-1:0] Data_out;
   logic              Last_out;
   logic              User_out;
   logic              Ready_in;
   logic              Frame_done;
   logic              Ovf_out;

   modport master (
      output Valid_in, Data_in, Ready_in,
      input  Ready_out, Valid_out, Data_out, Last_out, User_out, Frame_done, Ovf_out
   );

   modport slave (
      input  Valid_in, Data_in, Ready_in,
      output Ready_out, Valid_out, Data_out, Last_out, User_out, Frame_done, Ovf_out
   );
endinterface

// File: rtl/stream_framer.sv
// Two-entry skid buffer that tags a pixel stream with start-of-frame/last markers.
// Optional sticky overflow flag enabled by defining STREAM_FRAMER_OVF_EN.
module stream_framer #(
   parameter int DATA_W    = 8,
   parameter int IMG_W     = 1280,
   parameter int IMG_H     = 720,
   parameter int LAST_MODE = 0
) (
   input logic           Clk,
   input logic           rst_n,
   stream_framer_if.slave bus
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [1:0]        count;
   logic [1:0]        count_next;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] tail;
   logic              ready;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic              frame_done;
   logic              push;
   logic              pop;
   logic              out_valid;
   logic              at_line_end;
   logic              at_frame_end;

   assign out_valid    = (count != 2'd0);
   assign push         = bus.Valid_in && ready;
   assign pop          = out_valid && bus.Ready_in;
   assign at_line_end  = (col == COL_LAST);
   assign at_frame_end = at_line_end && (row == ROW_LAST);

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 2'd1;
      else if (pop && !push)
         count_next = count - 2'd1;
   end

   // head is always the pixel presented downstream; tail only holds the skid entry
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
         ready <= 1'b0;
      end else begin
         count <= count_next;
         ready <= (count_next != 2'd2);
         if (pop) begin
            if (count == 2'd2) begin
               head <= tail;
               if (push)
                  tail <= bus.Data_in;
            end else if (push) begin
               head <= bus.Data_in;
            end
         end else if (push) begin
            if (count == 2'd0)
               head <= bus.Data_in;
            else
               tail <= bus.Data_in;
         end
      end
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pop && at_frame_end;
         if (pop) begin
            if (at_line_end) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

   assign bus.Ready_out  = ready;
   assign bus.Valid_out  = out_valid;
   assign bus.Data_out   = head;
   assign bus.User_out   = out_valid && (col == '0) && (row == '0);
   assign bus.Last_out   = out_valid && ((LAST_MODE != 0) ? at_line_end : at_frame_end);
   assign bus.Frame_done = frame_done;

`ifdef STREAM_FRAMER_OVF_EN
   logic ovf;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n)
         ovf <= 1'b0;
      else if (bus.Valid_in && !ready)
         ovf <= 1'b1;
   end

   assign bus.Ovf_out = ovf;
`else
   assign bus.Ovf_out = 1'b0;
`endif
endmodule

// File: tb/tb_stream_framer.sv
// Self-checking bench for stream_framer: LAST_MODE 0 and 1 instances share one
// stimulus stream and are compared against a queue-based reference model.
module tb_stream_framer;
   localparam int DATA_W = 8;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 2;
   localparam int FRAME  = IMG_W * IMG_H;
`ifdef STREAM_FRAMER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic Clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 Clk = ~Clk;

   stream_framer_if #(.DATA_W(DATA_W)) bus0 ();
   stream_framer_if #(.DATA_W(DATA_W)) bus1 ();

   assign bus1.Valid_in = bus0.Valid_in;
   assign bus1.Data_in  = bus0.Data_in;
   assign bus1.Ready_in = bus0.Ready_in;

   stream_framer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .LAST_MODE(0)) dut0 (
      .Clk(Clk), .rst_n(rst_n), .bus(bus0)
   );

   stream_framer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .LAST_MODE(1)) dut1 (
      .Clk(Clk), .rst_n(rst_n), .bus(bus1)
   );

   typedef struct {
      bit             v;
      logic [7:0]     d;
      bit             r;
      bit             expValid;
      logic [7:0]     expData;
      bit             expUser;
      bit             expLast0;
      bit             expLast1;
      bit             expDone;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] modelQ[$];
   bit         modelReady = 1'b0;
   int         modelBeats = 0;
   bit         modelDone  = 1'b0;
   bit         modelOvf   = 1'b0;
   logic [7:0] sentQ[$];
   logic [7:0] recvQ[$];
   int         dutDoneCount = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Expected outputs come from the pending-pixel queue and the count of completed beats.
   task automatic checkAgainstModel();
      bit expValid;
      int pos;
      expValid = (modelQ.size() != 0);
      pos      = modelBeats % FRAME;
      checkOutput("Ready_out", bus0.Ready_out, modelReady);
      checkOutput("Valid_out", bus0.Valid_out, expValid);
      checkOutput("Valid_out_m1", bus1.Valid_out, expValid);
      if (expValid) begin
         checkOutput("Data_out", bus0.Data_out, modelQ[0]);
         checkOutput("User_out", bus0.User_out, pos == 0);
         checkOutput("Last_out_m0", bus0.Last_out, pos == FRAME - 1);
         checkOutput("Last_out_m1", bus1.Last_out, (modelBeats % IMG_W) == IMG_W - 1);
      end else begin
         checkOutput("User_out_idle", bus0.User_out, 0);
         checkOutput("Last_out_idle", bus0.Last_out, 0);
      end
      checkOutput("Frame_done", bus0.Frame_done, modelDone);
      checkOutput("Ovf_out", bus0.Ovf_out, modelOvf && OVF_EN);
   endtask

   task automatic modelAdvance(input bit v, input logic [7:0] d, input bit r);
      bit push;
      bit pop;
      push = v && modelReady;
      pop  = (modelQ.size() != 0) && r;
      if (v && !modelReady)
         modelOvf = 1'b1;
      modelDone = 1'b0;
      if (pop) begin
         if ((modelBeats % FRAME) == FRAME - 1)
            modelDone = 1'b1;
         void'(modelQ.pop_front());
         modelBeats++;
      end
      if (push)
         modelQ.push_back(d);
      modelReady = (modelQ.size() < 2);
   endtask

   task automatic driveAndCheck(input bit v, input logic [7:0] d, input bit r);
      @(negedge Clk);
      bus0.Valid_in = v;
      bus0.Data_in  = d;
      bus0.Ready_in = r;
      checkAgainstModel();
      if (bus0.Frame_done)
         dutDoneCount++;
      if (bus0.Valid_out && r)
         recvQ.push_back(bus0.Data_out);
   endtask

   task automatic finishCycle(input bit v, input logic [7:0] d, input bit r);
      @(posedge Clk);
      modelAdvance(v, d, r);
   endtask

   task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
      bit accepted;
      accepted = v && modelReady;
      driveAndCheck(v, d, r);
      finishCycle(v, d, r);
      if (accepted)
         sentQ.push_back(d);
   endtask

   // Reset is asserted away from the clock edge so the clear must be asynchronous.
   task automatic doReset();
      bus0.Valid_in = 1'b0;
      bus0.Data_in  = '0;
      bus0.Ready_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_Valid_out", bus0.Valid_out, 0);
      checkOutput("rst_Last_out", bus0.Last_out, 0);
      checkOutput("rst_User_out", bus0.User_out, 0);
      checkOutput("rst_Frame_done", bus0.Frame_done, 0);
      checkOutput("rst_Ovf_out", bus0.Ovf_out, 0);
      checkOutput("rst_Data_out", bus0.Data_out, 0);
      checkOutput("rst_Ready_out", bus0.Ready_out, 0);
      modelQ.delete();
      modelReady = 1'b0;
      modelBeats = 0;
      modelDone  = 1'b0;
      modelOvf   = 1'b0;
      sentQ.delete();
      recvQ.delete();
      dutDoneCount = 0;
      @(negedge Clk);
      @(negedge Clk);
      rst_n = 1'b1;
      @(posedge Clk);
      modelAdvance(1'b0, '0, 1'b0);
      #1;
      checkOutput("rst_release_ready", bus0.Ready_out, 1);
   endtask

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 8'd1, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 8'd2, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 8'd3, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 8'd4, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 8'd5, 1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 8'd6, 1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'd7, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      $display("[TB] start");
      doReset();

      // Continuous frame 0..7 with both LAST_MODE instances side by side
      for (int i = 0; i < 11; i++) begin
         driveAndCheck(vecs[i].v, vecs[i].d, vecs[i].r);
         checkOutput("tbl_valid", bus0.Valid_out, vecs[i].expValid);
         if (vecs[i].expValid)
            checkOutput("tbl_data", bus0.Data_out, vecs[i].expData);
         checkOutput("tbl_user", bus0.User_out, vecs[i].expUser);
         checkOutput("tbl_last_m0", bus0.Last_out, vecs[i].expLast0);
         checkOutput("tbl_last_m1", bus1.Last_out, vecs[i].expLast1);
         checkOutput("tbl_done", bus0.Frame_done, vecs[i].expDone);
         finishCycle(vecs[i].v, vecs[i].d, vecs[i].r);
      end
      checkOutput("tbl_done_count", dutDoneCount, 1);

      // Downstream stall with Valid_in held high
      doReset();
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 8'(sentQ.size()), 1'b1);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 8'(sentQ.size()), 1'b0);
      #1;
      checkOutput("stall_ready_low", bus0.Ready_out, 0);
      checkOutput("stall_buffered", sentQ.size() - recvQ.size(), 2);
      for (int i = 0; i < 40 && recvQ.size() < 8; i++)
         applyStimulus(sentQ.size() < 8, 8'(sentQ.size()), 1'b1);
      checkOutput("stall_recv_count", recvQ.size(), 8);
      for (int i = 0; i < 8 && i < recvQ.size(); i++)
         checkOutput("stall_order", recvQ[i], i);

      // Random traffic over three frames
      doReset();
      for (int i = 0; i < 400 && modelBeats < 3 * FRAME; i++)
         applyStimulus(sentQ.size() < 3 * FRAME && $urandom_range(0, 3) != 0,
                       8'($urandom), $urandom_range(0, 3) != 0);
      applyStimulus(1'b0, '0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("rand_recv_count", recvQ.size(), 3 * FRAME);
      for (int i = 0; i < sentQ.size() && i < recvQ.size(); i++)
         checkOutput("rand_order", recvQ[i], sentQ[i]);
      checkOutput("rand_frame_done", dutDoneCount, 3);

      // Reset mid-frame after five beats
      doReset();
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 8'(8'hA0 + i), 1'b1);
      doReset();
      applyStimulus(1'b1, 8'h5C, 1'b1);
      @(negedge Clk);
      checkOutput("post_rst_valid", bus0.Valid_out, 1);
      checkOutput("post_rst_user", bus0.User_out, 1);
      checkOutput("post_rst_data", bus0.Data_out, 8'h5C);

      // Overflow: Valid_in while the buffer is full
      doReset();
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 8'(i), 1'b0);
      #1;
      checkOutput("ovf_set", bus0.Ovf_out, OVF_EN);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("ovf_held", bus0.Ovf_out, OVF_EN);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] timeout");
   end
endmodule
